// File: rtl/i2s_transmitter.sv
// rtl/i2s_transmitter.sv - I2S master transmitter: holding register, SCLK/LRCLK generation, MSB-first serialiser
//
// Ports:
//   CLK          system clock, all logic on posedge
//   RESET_N      asynchronous active-low reset
//   EN           run enable; low holds the serial side idle (holding register keeps working)
//   LeftIn       left channel sample
//   RightIn      right channel sample
//   SampleValid  LeftIn/RightIn pair valid
//   SampleReady  holding register empty; pair accepted on Valid & Ready at a CLK edge
//   SCLK         serial bit clock, period 2*ClkDiv CLK
//   LRCLK        word select: 0 = left slot, 1 = right slot
//   SD           serial data, updated only on SCLK falling toggles
//   FrameStart   one-CLK pulse when a left slot begins
//   Underrun     one-CLK pulse when a frame begins with no pair held

module i2s_transmitter #(
    parameter int AudioWidth = 8,
    parameter int SlotWidth  = 16,
    parameter int ClkDiv     = 4
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  EN,
    input  logic [AudioWidth-1:0] LeftIn,
    input  logic [AudioWidth-1:0] RightIn,
    input  logic                  SampleValid,
    output logic                  SampleReady,
    output logic                  SCLK,
    output logic                  LRCLK,
    output logic                  SD,
    output logic                  FrameStart,
    output logic                  Underrun
);

    localparam int DivW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
    localparam int BitW = $clog2(2 * SlotWidth);

    localparam logic [DivW-1:0] DivLast  = DivW'(ClkDiv - 1);
    localparam logic [BitW-1:0] BitLast  = BitW'(2 * SlotWidth - 1);
    localparam logic [BitW-1:0] SlotLen  = BitW'(SlotWidth);
    localparam logic [BitW-1:0] AudioLen = BitW'(AudioWidth);

    logic [DivW-1:0]       div_cnt;
    logic [BitW-1:0]       bit_cnt;
    logic                  hold_full;
    logic [AudioWidth-1:0] hold_left;
    logic [AudioWidth-1:0] hold_right;
    logic [AudioWidth-1:0] shift_left;
    logic [AudioWidth-1:0] shift_right;

    logic                  div_wrap;
    logic                  sclk_fall;
    logic                  frame_wrap;
    logic                  load;
    logic                  accept;
    logic [BitW-1:0]       bit_next;
    logic                  right_slot;
    logic [BitW-1:0]       slot_bit;
    logic [AudioWidth-1:0] sel;
    logic [AudioWidth-1:0] aligned;
    logic                  sd_next;

    assign SampleReady = ~hold_full;
    assign accept      = SampleValid & ~hold_full;

    always_comb begin
        div_wrap   = (div_cnt == DivLast);
        sclk_fall  = EN & div_wrap & SCLK;
        frame_wrap = (bit_cnt == BitLast);
        load       = sclk_fall & frame_wrap;
        bit_next   = frame_wrap ? '0 : bit_cnt + BitW'(1);
        right_slot = (bit_next >= SlotLen);
        slot_bit   = right_slot ? (bit_next - SlotLen) : bit_next;
        sel        = right_slot ? shift_right : shift_left;
        // Slot bit b (1..AudioWidth) carries sel[AudioWidth-b]; shifting left by b-1
        // brings that bit to the MSB. b=0 is the I2S delay bit; bits past the sample pad with 0.
        // On the load edge bit_next is 0, so the stale shift contents are never emitted.
        aligned    = sel << (slot_bit - BitW'(1));
        sd_next    = 1'b0;
        if ((slot_bit != '0) && (slot_bit <= AudioLen)) begin
            sd_next = aligned[AudioWidth-1];
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            div_cnt     <= '0;
            bit_cnt     <= BitLast;
            SCLK        <= 1'b0;
            LRCLK       <= 1'b1;
            SD          <= 1'b0;
            FrameStart  <= 1'b0;
            Underrun    <= 1'b0;
            shift_left  <= '0;
            shift_right <= '0;
        end else if (!EN) begin
            // Discard any partial frame; restart lands on bit 0 at the first fall.
            div_cnt    <= '0;
            bit_cnt    <= BitLast;
            SCLK       <= 1'b0;
            LRCLK      <= 1'b1;
            SD         <= 1'b0;
            FrameStart <= 1'b0;
            Underrun   <= 1'b0;
        end else begin
            FrameStart <= 1'b0;
            Underrun   <= 1'b0;
            div_cnt    <= div_wrap ? '0 : div_cnt + DivW'(1);
            if (div_wrap) begin
                SCLK <= ~SCLK;
            end
            if (sclk_fall) begin
                bit_cnt <= bit_next;
                LRCLK   <= right_slot;
                SD      <= sd_next;
            end
            if (load) begin
                FrameStart  <= 1'b1;
                Underrun    <= ~hold_full;
                shift_left  <= hold_full ? hold_left  : '0;
                shift_right <= hold_full ? hold_right : '0;
            end
        end
    end

    // Load and accept never coincide while full (Ready is low), so an accept
    // alongside an empty load simply fills the holding register for the next frame.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hold_full  <= 1'b0;
            hold_left  <= '0;
            hold_right <= '0;
        end else begin
            if (load && hold_full) begin
                hold_full <= 1'b0;
            end else if (accept) begin
                hold_full <= 1'b1;
            end
            if (accept) begin
                hold_left  <= LeftIn;
                hold_right <= RightIn;
            end
        end
    end

endmodule

// File: tb/tb_i2s_transmitter.sv
// tb/tb_i2s_transmitter.sv - directed self-checking bench for i2s_transmitter at default parameters

module tb_i2s_transmitter;

    logic       CLK;
    logic       RESET_N;
    logic       EN;
    logic [7:0] LeftIn;
    logic [7:0] RightIn;
    logic       SampleValid;
    logic       SampleReady;
    logic       SCLK;
    logic       LRCLK;
    logic       SD;
    logic       FrameStart;
    logic       Underrun;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit sd_log [2048];

    i2s_transmitter #(.AudioWidth(8), .SlotWidth(16), .ClkDiv(4)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .EN(EN),
        .LeftIn(LeftIn), .RightIn(RightIn),
        .SampleValid(SampleValid), .SampleReady(SampleReady),
        .SCLK(SCLK), .LRCLK(LRCLK), .SD(SD),
        .FrameStart(FrameStart), .Underrun(Underrun)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        sd_log[cyc] = SD;
    endtask

    task automatic tick_to(input int n);
        while (cyc < n) tick();
    endtask

    // Slot word as sent, MSB-first string: bit j of the slot sits at position 15-j.
    // Bit j of a frame starting at edge s is sampled on the SCLK rise at s+4+8j.
    function automatic logic [15:0] slot_word(input int start, input int right);
        logic [15:0] w;
        for (int j = 0; j < 16; j++) w[15-j] = sd_log[start + 4 + 8 * (j + 16 * right)];
        return w;
    endfunction

    initial begin
        int acc;
        int rdy_hi;
        int viol;
        int sd_any;
        logic rdy_prev;
        logic [15:0] k;

        RESET_N = 1'b0; EN = 1'b1; SampleValid = 1'b0; LeftIn = '0; RightIn = '0;
        #12;
        check("rst_sclk",  SCLK, 0);
        check("rst_lrclk", LRCLK, 1);
        check("rst_sd",    SD, 0);
        check("rst_fs",    FrameStart, 0);
        check("rst_ur",    Underrun, 0);
        check("rst_ready", SampleReady, 1);

        // Basic frame: accept A5/3C on edge 1
        SampleValid = 1'b1; LeftIn = 8'hA5; RightIn = 8'h3C;
        RESET_N = 1'b1;
        tick();
        SampleValid = 1'b0;
        check("ready_low_after_accept", SampleReady, 0);
        tick_to(4);
        check("first_sclk_rise", SCLK, 1);
        tick_to(7);
        check("fs_before", FrameStart, 0);
        tick();
        check("fs_at_8", FrameStart, 1);
        check("ur_at_8", Underrun, 0);
        check("lrclk_left_at_8", LRCLK, 0);
        check("ready_back_at_8", SampleReady, 1);
        tick();
        check("fs_one_cycle", FrameStart, 0);
        tick_to(135);
        check("lrclk_135", LRCLK, 0);
        tick();
        check("lrclk_136", LRCLK, 1);
        tick_to(263);
        check("f1_left",  slot_word(8, 0), 16'h5280);
        check("f1_right", slot_word(8, 1), 16'h1E00);

        // Underrun frame
        tick();
        check("f2_fs", FrameStart, 1);
        check("f2_ur", Underrun, 1);
        tick_to(519);
        sd_any = 0;
        for (int i = 264; i <= 519; i++) sd_any |= int'(sd_log[i]);
        check("f2_sd_zero", sd_any, 0);

        // Accept FF/01 on the frame-start edge 520
        SampleValid = 1'b1; LeftIn = 8'hFF; RightIn = 8'h01;
        tick();
        SampleValid = 1'b0;
        check("f3_fs", FrameStart, 1);
        check("f3_ur", Underrun, 1);
        check("f3_ready_low", SampleReady, 0);
        tick_to(776);
        check("f4_fs", FrameStart, 1);
        check("f4_ur", Underrun, 0);
        check("f4_ready", SampleReady, 1);

        // Backpressure: new data each cycle through edge 1288
        k = 16'h0010;
        SampleValid = 1'b1; LeftIn = k[7:0]; RightIn = ~k[7:0];
        acc = 0; rdy_hi = 0;
        while (cyc < 1288) begin
            rdy_prev = SampleReady;
            tick();
            if (rdy_prev) acc++;
            if (cyc >= 777 && cyc <= 1031 && SampleReady) rdy_hi++;
            if (cyc == 1032) check("bp_ready_at_frame", SampleReady, 1);
            k = k + 16'd1;
            LeftIn = k[7:0]; RightIn = ~k[7:0];
        end
        SampleValid = 1'b0;
        check("bp_accept_count", acc, 2);
        check("bp_ready_low", rdy_hi, 0);
        check("f4_left",  slot_word(776, 0), 16'h7F80);
        check("f4_right", slot_word(776, 1), 16'h0080);
        check("f5_left",  slot_word(1032, 0), 16'h0800);
        check("f5_right", slot_word(1032, 1), 16'h7780);

        // Enable drop mid-right-slot with a pair held
        SampleValid = 1'b1; LeftIn = 8'hC3; RightIn = 8'h5A;
        tick();
        SampleValid = 1'b0;
        check("en_hold_filled", SampleReady, 0);
        tick_to(1450);
        check("en_in_right_slot", LRCLK, 1);
        EN = 1'b0;
        viol = 0;
        while (cyc < 1500) begin
            tick();
            if (SCLK !== 1'b0 || LRCLK !== 1'b1 || SD !== 1'b0 || FrameStart !== 1'b0) viol++;
        end
        check("en_idle_outputs", viol, 0);
        check("en_hold_kept", SampleReady, 0);
        EN = 1'b1;
        tick_to(1504);
        check("en_first_rise", SCLK, 1);
        tick_to(1508);
        check("en_fs", FrameStart, 1);
        check("en_ur", Underrun, 0);
        check("en_lrclk", LRCLK, 0);
        check("en_ready", SampleReady, 1);
        tick_to(1763);
        check("en_left",  slot_word(1508, 0), 16'h6180);
        check("en_right", slot_word(1508, 1), 16'h2D00);

        // Reset mid-frame with SCLK high, left slot and a pair held
        tick();
        SampleValid = 1'b1; LeftIn = 8'h11; RightIn = 8'h22;
        tick();
        SampleValid = 1'b0;
        tick_to(1786);
        check("pre_rst_sclk", SCLK, 1);
        check("pre_rst_ready", SampleReady, 0);
        #2;
        RESET_N = 1'b0;
        #1;
        check("mid_rst_sclk",  SCLK, 0);
        check("mid_rst_lrclk", LRCLK, 1);
        check("mid_rst_sd",    SD, 0);
        check("mid_rst_fs",    FrameStart, 0);
        check("mid_rst_ur",    Underrun, 0);
        check("mid_rst_ready", SampleReady, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
